// File: rtl/ps2_pkg.sv
// Shared PS/2 definitions: host transmitter states, keyboard command bytes
// and the frame-building helpers used by the host transmitter.
package ps2_pkg;

    typedef enum logic [2:0] {
        IDLE,
        INHIBIT,
        REQ,
        SEND,
        ACK,
        WAIT_IDLE
    } ps2_tx_state_e;

    localparam logic [7:0] PS2_CMD_SET_LED = 8'hED;
    localparam logic [7:0] PS2_CMD_RESET   = 8'hFF;
    localparam logic [7:0] PS2_CMD_ENABLE  = 8'hF4;
    localparam logic [7:0] PS2_ACK_BYTE    = 8'hFA;

    // Odd parity: the parity bit makes the total count of ones in data+parity odd.
    function automatic logic odd_parity(input logic [7:0] data);
        return ~^data;
    endfunction

    // Bits shifted out after the start bit, LSB first: data, parity, stop.
    function automatic logic [9:0] tx_frame(input logic [7:0] data);
        return {1'b1, odd_parity(data), data};
    endfunction

endpackage

// File: rtl/ps2_sync_edge.sv
// Brings the raw PS/2 clock and data lines into the CLOCK_50 domain and
// flags falling edges of the synchronised clock. Shared with the keyboard
// receiver so both sides see identical line timing.
module ps2_sync_edge (
    input  logic CLOCK_50,
    input  logic reset,
    input  logic ps2_clk_in,
    input  logic ps2_dat_in,
    output logic clk_sync,
    output logic dat_sync,
    output logic clk_fall
);

    logic clk_meta_q, clk_meta_d;
    logic clk_sync_q, clk_sync_d;
    logic clk_prev_q, clk_prev_d;
    logic dat_meta_q, dat_meta_d;
    logic dat_sync_q, dat_sync_d;

    // Next values for the two-stage synchronisers and the clock history flop.
    always_comb begin
        clk_meta_d = ps2_clk_in;
        clk_sync_d = clk_meta_q;
        clk_prev_d = clk_sync_q;
        dat_meta_d = ps2_dat_in;
        dat_sync_d = dat_meta_q;
    end

    // Idle PS/2 lines are high, so everything resets to 1 to avoid a false edge.
    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            clk_meta_q <= 1'b1;
            clk_sync_q <= 1'b1;
            clk_prev_q <= 1'b1;
            dat_meta_q <= 1'b1;
            dat_sync_q <= 1'b1;
        end else begin
            clk_meta_q <= clk_meta_d;
            clk_sync_q <= clk_sync_d;
            clk_prev_q <= clk_prev_d;
            dat_meta_q <= dat_meta_d;
            dat_sync_q <= dat_sync_d;
        end
    end

    assign clk_sync = clk_sync_q;
    assign dat_sync = dat_sync_q;
    assign clk_fall = clk_prev_q & ~clk_sync_q;

endmodule

// File: rtl/ps2_host_tx.sv
// Host-to-keyboard PS/2 transmitter. Inhibits the bus, asserts the start
// bit, shifts a byte out on device clock falls and checks the device ACK.
// The FPGA top level turns the enables into open-drain pins:
// PS2_KBCLK = ps2_clk_oe ? 1'b0 : 1'bz, and likewise for PS2_KBDAT.
module ps2_host_tx
    import ps2_pkg::*;
#(
    parameter int INHIBIT_CYCLES = 5000,
    parameter int TIMEOUT_CYCLES = 1000000
) (
    input  logic       CLOCK_50,
    input  logic       reset,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic       busy,
    output logic       tx_done,
    output logic       tx_error,
    input  logic       ps2_clk_in,
    input  logic       ps2_dat_in,
    output logic       ps2_clk_oe,
    output logic       ps2_dat_oe
);

    localparam int INH_W = $clog2(INHIBIT_CYCLES + 1);
    localparam int TO_W  = $clog2(TIMEOUT_CYCLES + 1);

    localparam logic [INH_W-1:0] INH_LAST = INH_W'(INHIBIT_CYCLES - 1);
    localparam logic [INH_W-1:0] INH_MAX  = INH_W'(INHIBIT_CYCLES);
    localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(TIMEOUT_CYCLES - 1);
    localparam logic [TO_W-1:0]  TO_MAX   = TO_W'(TIMEOUT_CYCLES);

    logic clk_sync;
    logic dat_sync;
    logic clk_fall;

    ps2_sync_edge u_sync (
        .CLOCK_50   (CLOCK_50),
        .reset      (reset),
        .ps2_clk_in (ps2_clk_in),
        .ps2_dat_in (ps2_dat_in),
        .clk_sync   (clk_sync),
        .dat_sync   (dat_sync),
        .clk_fall   (clk_fall)
    );

    ps2_tx_state_e    state_q, state_d;
    logic [9:0]       shreg_q, shreg_d;
    logic [3:0]       bit_cnt_q, bit_cnt_d;
    logic [INH_W-1:0] inh_cnt_q, inh_cnt_d;
    logic [TO_W-1:0]  to_cnt_q, to_cnt_d;
    logic             ok_q, ok_d;
    logic             clk_oe_q, clk_oe_d;
    logic             dat_oe_q, dat_oe_d;
    logic             tx_ready_q, tx_ready_d;
    logic             busy_q, busy_d;
    logic             tx_done_q, tx_done_d;
    logic             tx_error_q, tx_error_d;
    logic             to_active;
    logic             to_inc_ok;

    // Next-state, shift register, counters and line enables; the timeout overrides everything else.
    always_comb begin
        state_d    = state_q;
        shreg_d    = shreg_q;
        bit_cnt_d  = bit_cnt_q;
        inh_cnt_d  = inh_cnt_q;
        to_cnt_d   = to_cnt_q;
        ok_d       = ok_q;
        clk_oe_d   = clk_oe_q;
        dat_oe_d   = dat_oe_q;
        tx_done_d  = 1'b0;
        tx_error_d = 1'b0;
        to_active  = 1'b0;
        to_inc_ok  = (to_cnt_q != TO_MAX);

        case (state_q)
            IDLE: begin
                clk_oe_d = 1'b0;
                dat_oe_d = 1'b0;
                if (tx_valid && tx_ready_q) begin
                    shreg_d   = tx_frame(tx_data);
                    bit_cnt_d = '0;
                    inh_cnt_d = '0;
                    to_cnt_d  = '0;
                    ok_d      = 1'b0;
                    clk_oe_d  = 1'b1;
                    state_d   = INHIBIT;
                end
            end
            INHIBIT: begin
                clk_oe_d = 1'b1;
                dat_oe_d = 1'b0;
                if (inh_cnt_q == INH_LAST) begin
                    dat_oe_d = 1'b1;
                    state_d  = REQ;
                end else if (inh_cnt_q != INH_MAX) begin
                    inh_cnt_d = inh_cnt_q + INH_W'(1);
                end
            end
            REQ: begin
                clk_oe_d  = 1'b0;
                dat_oe_d  = 1'b1;
                to_cnt_d  = '0;
                bit_cnt_d = '0;
                state_d   = SEND;
            end
            SEND: begin
                to_active = 1'b1;
                clk_oe_d  = 1'b0;
                if (clk_fall) begin
                    dat_oe_d = ~shreg_q[0];
                    shreg_d  = {1'b0, shreg_q[9:1]};
                    to_cnt_d = '0;
                    if (bit_cnt_q == 4'd9) begin
                        state_d = ACK;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 4'd1;
                    end
                end else if (to_inc_ok) begin
                    to_cnt_d = to_cnt_q + TO_W'(1);
                end
            end
            ACK: begin
                to_active = 1'b1;
                clk_oe_d  = 1'b0;
                dat_oe_d  = 1'b0;
                if (clk_fall) begin
                    ok_d     = ~dat_sync;
                    to_cnt_d = '0;
                    state_d  = WAIT_IDLE;
                end else if (to_inc_ok) begin
                    to_cnt_d = to_cnt_q + TO_W'(1);
                end
            end
            WAIT_IDLE: begin
                to_active = 1'b1;
                clk_oe_d  = 1'b0;
                dat_oe_d  = 1'b0;
                if (clk_sync && dat_sync) begin
                    tx_done_d  = ok_q;
                    tx_error_d = ~ok_q;
                    state_d    = IDLE;
                end else if (clk_fall) begin
                    to_cnt_d = '0;
                end else if (to_inc_ok) begin
                    to_cnt_d = to_cnt_q + TO_W'(1);
                end
            end
            default: begin
                clk_oe_d = 1'b0;
                dat_oe_d = 1'b0;
                state_d  = IDLE;
            end
        endcase

        if (to_active && (to_cnt_q == TO_LAST)) begin
            clk_oe_d   = 1'b0;
            dat_oe_d   = 1'b0;
            tx_done_d  = 1'b0;
            tx_error_d = 1'b1;
            state_d    = IDLE;
        end

        tx_ready_d = (state_d == IDLE) && !tx_done_d && !tx_error_d;
        busy_d     = (state_d != IDLE);
    end

    // All FSM state and outputs are registered; reset releases both lines at once.
    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            shreg_q    <= '0;
            bit_cnt_q  <= '0;
            inh_cnt_q  <= '0;
            to_cnt_q   <= '0;
            ok_q       <= 1'b0;
            clk_oe_q   <= 1'b0;
            dat_oe_q   <= 1'b0;
            tx_ready_q <= 1'b1;
            busy_q     <= 1'b0;
            tx_done_q  <= 1'b0;
            tx_error_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            shreg_q    <= shreg_d;
            bit_cnt_q  <= bit_cnt_d;
            inh_cnt_q  <= inh_cnt_d;
            to_cnt_q   <= to_cnt_d;
            ok_q       <= ok_d;
            clk_oe_q   <= clk_oe_d;
            dat_oe_q   <= dat_oe_d;
            tx_ready_q <= tx_ready_d;
            busy_q     <= busy_d;
            tx_done_q  <= tx_done_d;
            tx_error_q <= tx_error_d;
        end
    end

    assign tx_ready   = tx_ready_q;
    assign busy       = busy_q;
    assign tx_done    = tx_done_q;
    assign tx_error   = tx_error_q;
    assign ps2_clk_oe = clk_oe_q;
    assign ps2_dat_oe = dat_oe_q;

endmodule

// File: tb/tb_ps2_host_tx.sv
// Bench for ps2_host_tx: a keyboard BFM clocks frames out of the host,
// expected responses go into a scoreboard queue and a monitor pops them
// whenever tx_done or tx_error pulses.
module tb_ps2_host_tx;
    import ps2_pkg::*;

    localparam int INH      = 5000;
    localparam int TO       = 4000;
    localparam int HALF     = 40;
    localparam int SYNC_LAT = 2;

    logic       CLOCK_50 = 1'b0;
    logic       reset    = 1'b1;
    logic [7:0] tx_data  = 8'h00;
    logic       tx_valid = 1'b0;
    logic       tx_ready;
    logic       busy;
    logic       tx_done;
    logic       tx_error;
    logic       ps2_clk_in;
    logic       ps2_dat_in;
    logic       ps2_clk_oe;
    logic       ps2_dat_oe;

    logic dev_clk = 1'b1;
    logic dev_dat = 1'b1;

    typedef struct {
        logic done;
        logic err;
        logic chk_cyc;
        int   at_cyc;
    } resp_t;

    resp_t resp_q[$];
    logic  exp_bits[$];
    resp_t mon_r;
    int    checks   = 0;
    int    failures = 0;
    int    cyc      = 0;
    int    lf;
    int    inh_len;

    ps2_host_tx #(
        .INHIBIT_CYCLES (INH),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .CLOCK_50   (CLOCK_50),
        .reset      (reset),
        .tx_data    (tx_data),
        .tx_valid   (tx_valid),
        .tx_ready   (tx_ready),
        .busy       (busy),
        .tx_done    (tx_done),
        .tx_error   (tx_error),
        .ps2_clk_in (ps2_clk_in),
        .ps2_dat_in (ps2_dat_in),
        .ps2_clk_oe (ps2_clk_oe),
        .ps2_dat_oe (ps2_dat_oe)
    );

    // Open-drain bus: either side can pull a line low.
    assign ps2_clk_in = dev_clk & ~ps2_clk_oe;
    assign ps2_dat_in = dev_dat & ~ps2_dat_oe;

    always #10 CLOCK_50 = ~CLOCK_50;

    always @(posedge CLOCK_50) cyc <= cyc + 1;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    // Monitor: every done/error pulse must match the oldest expected response.
    always @(negedge CLOCK_50) begin
        if (!reset && (tx_done || tx_error)) begin
            checkOutput("ready_low_during_pulse", tx_ready, 1'b0);
            if (resp_q.size() == 0) begin
                checks++;
                failures++;
                $display("[TB] FAIL unexpected_resp: got done=%0b error=%0b, expected no pulse", tx_done, tx_error);
            end else begin
                mon_r = resp_q.pop_front();
                checkOutput("resp_done", tx_done, mon_r.done);
                checkOutput("resp_error", tx_error, mon_r.err);
                if (mon_r.chk_cyc) checkOutput("resp_cycle", cyc, mon_r.at_cyc);
            end
        end
    end

    task automatic wait_ticks(input int n);
        repeat (n) @(posedge CLOCK_50);
        #1;
    endtask

    task automatic push_resp(input logic done, input logic err, input logic chk, input int at);
        resp_t r;
        r.done    = done;
        r.err     = err;
        r.chk_cyc = chk;
        r.at_cyc  = at;
        resp_q.push_back(r);
    endtask

    task automatic wait_accept(input int limit);
        int   n;
        logic got;
        n   = 0;
        got = 1'b0;
        while (!got && n < limit) begin
            @(negedge CLOCK_50);
            if (tx_ready && tx_valid) got = 1'b1;
            else n++;
        end
        if (got) begin
            @(posedge CLOCK_50);
            #1;
        end
        checkOutput("accept", got, 1'b1);
    endtask

    task automatic wait_resp_drain(input int limit);
        int n;
        n = 0;
        while (resp_q.size() != 0 && n < limit) begin
            wait_ticks(1);
            n++;
        end
        checkOutput("resp_drain", resp_q.size(), 0);
        resp_q.delete();
    endtask

    // Queues the bits the device should see at its rising edges, then offers the byte.
    task automatic applyStimulus(input logic [7:0] d, input logic par, input int nbits, input logic hold);
        for (int i = 0; i < nbits; i++) begin
            if (i < 8) exp_bits.push_back(d[i]);
            else if (i == 8) exp_bits.push_back(par);
            else exp_bits.push_back(1'b1);
        end
        tx_data  = d;
        tx_valid = 1'b1;
        wait_accept(30000);
        if (!hold) tx_valid = 1'b0;
    endtask

    // Keyboard BFM: waits for the request, clocks nfalls falls, samples data before each rise.
    task automatic device_frame(input int nfalls, input logic do_ack, output int last_fall_cyc);
        int   guard;
        logic exp;
        last_fall_cyc = 0;
        guard = 0;
        while (!(ps2_clk_in && !ps2_dat_in && !ps2_clk_oe) && guard < 20000) begin
            wait_ticks(1);
            guard++;
        end
        checkOutput("request_seen", (guard < 20000), 1'b1);
        if (guard >= 20000) return;
        wait_ticks(HALF);
        for (int i = 1; i <= nfalls && i <= 10; i++) begin
            dev_clk = 1'b0;
            last_fall_cyc = cyc;
            wait_ticks(HALF);
            if (exp_bits.size() > 0) begin
                exp = exp_bits.pop_front();
                checkOutput($sformatf("bit%0d", i), ps2_dat_in, exp);
            end else begin
                checks++;
                failures++;
                $display("[TB] FAIL bit%0d: got %0b, expected no bit queued", i, ps2_dat_in);
            end
            dev_clk = 1'b1;
            wait_ticks(HALF);
        end
        if (nfalls >= 11) begin
            if (do_ack) begin
                dev_dat = 1'b0;
                wait_ticks(5);
            end
            dev_clk = 1'b0;
            last_fall_cyc = cyc;
            wait_ticks(HALF);
            dev_clk = 1'b1;
            wait_ticks(10);
            dev_dat = 1'b1;
            wait_ticks(1);
        end
    endtask

    initial begin
        #4000000;
        $display("[TB] FAIL watchdog: got no finish, expected finish within time limit");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        // Reset values, sampled while reset is held.
        wait_ticks(3);
        checkOutput("rst_tx_ready", tx_ready, 1'b1);
        checkOutput("rst_busy", busy, 1'b0);
        checkOutput("rst_tx_done", tx_done, 1'b0);
        checkOutput("rst_tx_error", tx_error, 1'b0);
        checkOutput("rst_clk_oe", ps2_clk_oe, 1'b0);
        checkOutput("rst_dat_oe", ps2_dat_oe, 1'b0);
        reset = 1'b0;
        wait_ticks(5);

        // Device-initiated falls while idle must be ignored.
        $display("[TB] idle device clocking");
        for (int i = 0; i < 3; i++) begin
            dev_clk = 1'b0;
            wait_ticks(HALF);
            dev_clk = 1'b1;
            wait_ticks(HALF);
            checkOutput("idle_busy", busy, 1'b0);
            checkOutput("idle_ready", tx_ready, 1'b1);
            checkOutput("idle_clk_oe", ps2_clk_oe, 1'b0);
            checkOutput("idle_dat_oe", ps2_dat_oe, 1'b0);
        end

        // LED-set command with a measured inhibit interval.
        $display("[TB] send 0xED");
        push_resp(1'b1, 1'b0, 1'b0, 0);
        applyStimulus(PS2_CMD_SET_LED, 1'b1, 10, 1'b0);
        inh_len = 0;
        @(negedge CLOCK_50);
        while (ps2_clk_oe && !ps2_dat_oe && inh_len < INH + 100) begin
            inh_len++;
            @(negedge CLOCK_50);
        end
        checkOutput("inhibit_len", inh_len, INH);
        checkOutput("req_clk_oe", ps2_clk_oe, 1'b1);
        checkOutput("req_dat_oe", ps2_dat_oe, 1'b1);
        device_frame(11, 1'b1, lf);
        wait_resp_drain(200);

        // Back to back 0x01 then 0xFF with tx_valid held high.
        $display("[TB] send 0x01 then 0xFF");
        push_resp(1'b1, 1'b0, 1'b0, 0);
        push_resp(1'b1, 1'b0, 1'b0, 0);
        applyStimulus(8'h01, 1'b0, 10, 1'b1);
        for (int i = 0; i < 8; i++) exp_bits.push_back(1'b1);
        exp_bits.push_back(1'b1);
        exp_bits.push_back(1'b1);
        tx_data = PS2_CMD_RESET;
        device_frame(11, 1'b1, lf);
        wait_accept(200);
        tx_valid = 1'b0;
        device_frame(11, 1'b1, lf);
        wait_resp_drain(200);
        wait_ticks(200);
        checkOutput("no_third_frame_busy", busy, 1'b0);
        checkOutput("no_third_frame_ready", tx_ready, 1'b1);

        // Device never acknowledges.
        $display("[TB] send 0xFA without ACK");
        push_resp(1'b0, 1'b1, 1'b0, 0);
        applyStimulus(PS2_ACK_BYTE, 1'b1, 10, 1'b0);
        device_frame(11, 1'b0, lf);
        wait_resp_drain(200);
        checkOutput("noack_clk_oe", ps2_clk_oe, 1'b0);
        checkOutput("noack_dat_oe", ps2_dat_oe, 1'b0);

        // Device stops after fall 4; error fires TO cycles after the host registers that fall.
        $display("[TB] send 0x3C, device stalls");
        applyStimulus(8'h3C, 1'b1, 4, 1'b0);
        device_frame(4, 1'b1, lf);
        push_resp(1'b0, 1'b1, 1'b1, lf + TO + SYNC_LAT + 1);
        wait_resp_drain(TO + 500);
        wait_ticks(1);
        checkOutput("timeout_clk_oe", ps2_clk_oe, 1'b0);
        checkOutput("timeout_dat_oe", ps2_dat_oe, 1'b0);
        checkOutput("timeout_ready", tx_ready, 1'b1);

        // Async reset right after fall 6 of a 0x00 frame.
        $display("[TB] reset mid-frame");
        applyStimulus(8'h00, 1'b1, 5, 1'b0);
        device_frame(5, 1'b1, lf);
        dev_clk = 1'b0;
        wait_ticks(6);
        checkOutput("pre_reset_dat_oe", ps2_dat_oe, 1'b1);
        checkOutput("pre_reset_busy", busy, 1'b1);
        #3;
        reset = 1'b1;
        #1;
        checkOutput("mid_reset_clk_oe", ps2_clk_oe, 1'b0);
        checkOutput("mid_reset_dat_oe", ps2_dat_oe, 1'b0);
        checkOutput("mid_reset_busy", busy, 1'b0);
        dev_clk = 1'b1;
        wait_ticks(5);
        reset = 1'b0;
        wait_ticks(5);

        $display("[TB] send 0xF4 after reset");
        push_resp(1'b1, 1'b0, 1'b0, 0);
        applyStimulus(PS2_CMD_ENABLE, 1'b0, 10, 1'b0);
        device_frame(11, 1'b1, lf);
        wait_resp_drain(200);

        wait_ticks(20);
        checkOutput("end_resp_queue", resp_q.size(), 0);
        checkOutput("end_bits_queue", exp_bits.size(), 0);
        checkOutput("end_busy", busy, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
